// File: rtl/ttl_out_line_if.sv
// Control/status bundle for the TTL test-pattern transmitter.
// The master side (sequencer or bench) drives requests; the slave side
// (ttl_out_line) drives the line and its status.
interface ttl_out_line_if #(
  parameter int LEN_W = 16
) ();

  logic             start;
  logic             stop;
  logic [LEN_W-1:0] burst_len;
  logic [1:0]       fault;
  logic             clk_out;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] period_cnt;

  modport master (
    output start, stop, burst_len, fault,
    input  clk_out, busy, done, period_cnt
  );

  modport slave (
    input  start, stop, burst_len, fault,
    output clk_out, busy, done, period_cnt
  );

endinterface

// File: rtl/ttl_out_line.sv
// ttl_out_line: square-wave test-pattern transmitter for the TTL line
// checker. Sends counted or continuous bursts of HALF_PERIOD-high /
// HALF_PERIOD-low periods on clk_out.
//
// Build option: define TTL_OUT_FAULT_EN to implement the fault input
// (short high halves, short low halves, periodic line stall). Without it
// the fault input is ignored and only the nominal waveform is produced.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line low, waiting for start; period_cnt holds last result
// HIGH   | line high for the (possibly shortened) high half
// LOW    | line low for the (possibly shortened) low half; period ends
// STALL  | line held low for STALL_CYCLES before each normal period
module ttl_out_line #(
  parameter int HALF_PERIOD  = 50,
  parameter int SHORT_HALF   = 20,
  parameter int STALL_CYCLES = 200,
  parameter int LEN_W        = 16
) (
  input logic         clk_fpga,
  input logic         rst_n,
  ttl_out_line_if.slave bus
);

`ifdef TTL_OUT_FAULT_EN
  localparam int CNT_MAX = (HALF_PERIOD > STALL_CYCLES) ? HALF_PERIOD : STALL_CYCLES;
`else
  localparam int CNT_MAX = HALF_PERIOD;
`endif
  localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  // Counters are loaded with length-1 and run down to a terminal count of 0.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
`ifdef TTL_OUT_FAULT_EN
    , S_STALL
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pcnt_q;
  logic [LEN_W-1:0] pcnt_nxt;
  logic             stop_pend;
  logic             clk_out_q;
  logic             busy_q;
  logic             done_q;
  logic             burst_end;
  logic [CNT_W-1:0] h_load_start;
  logic [CNT_W-1:0] h_load_run;
  logic [CNT_W-1:0] l_load;

`ifdef TTL_OUT_FAULT_EN
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_HALF - 1);
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);

  logic [1:0] fault_q;
  logic       stall_mode;

  // Half-period lengths: the first high half uses the fault on the bus
  // because fault_q is only being written in that same cycle.
  always_comb begin
    h_load_start = (bus.fault == 2'b01) ? SHORT_LOAD : HALF_LOAD;
    h_load_run   = (fault_q == 2'b01) ? SHORT_LOAD : HALF_LOAD;
    l_load       = (fault_q == 2'b10) ? SHORT_LOAD : HALF_LOAD;
  end

  assign stall_mode = (fault_q == 2'b11);
`else
  logic unused_fault;

  assign h_load_start = HALF_LOAD;
  assign h_load_run   = HALF_LOAD;
  assign l_load       = HALF_LOAD;
  assign unused_fault = ^bus.fault;
`endif

  assign pcnt_nxt  = pcnt_q + LEN_W'(1);
  // A stop request only takes effect once the running period is complete.
  assign burst_end = stop_pend || ((len_q != '0) && (pcnt_nxt == len_q));

  // Sequencer: state, half-period timer and all registered outputs.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      pcnt_q    <= '0;
      stop_pend <= 1'b0;
      clk_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TTL_OUT_FAULT_EN
      fault_q   <= 2'b00;
`endif
    end else begin
      done_q <= 1'b0;
      if ((state != S_IDLE) && bus.stop) begin
        stop_pend <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          clk_out_q <= 1'b0;
          if (bus.start) begin
            len_q     <= bus.burst_len;
            pcnt_q    <= '0;
            stop_pend <= 1'b0;
            busy_q    <= 1'b1;
`ifdef TTL_OUT_FAULT_EN
            fault_q   <= bus.fault;
            if (bus.fault == 2'b11) begin
              state     <= S_STALL;
              cnt       <= STALL_LOAD;
              clk_out_q <= 1'b0;
            end else begin
              state     <= S_HIGH;
              cnt       <= h_load_start;
              clk_out_q <= 1'b1;
            end
`else
            state     <= S_HIGH;
            cnt       <= h_load_start;
            clk_out_q <= 1'b1;
`endif
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            state     <= S_LOW;
            cnt       <= l_load;
            clk_out_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_LOW: begin
          if (cnt == '0) begin
            pcnt_q <= pcnt_nxt;
            if (burst_end) begin
              state     <= S_IDLE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              clk_out_q <= 1'b0;
`ifdef TTL_OUT_FAULT_EN
            end else if (stall_mode) begin
              state     <= S_STALL;
              cnt       <= STALL_LOAD;
              clk_out_q <= 1'b0;
`endif
            end else begin
              state     <= S_HIGH;
              cnt       <= h_load_run;
              clk_out_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef TTL_OUT_FAULT_EN
        S_STALL: begin
          if (cnt == '0) begin
            state     <= S_HIGH;
            cnt       <= h_load_run;
            clk_out_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          clk_out_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out    = clk_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.period_cnt = pcnt_q;

endmodule

// File: tb/tb_ttl_out_line.sv
// Bench for ttl_out_line. A behavioural model of the waveform pushes the
// expected per-cycle line/status values into a queue when a burst is
// launched; the observed values are collected cycle by cycle and each
// scenario task compares them. Honours TTL_OUT_FAULT_EN the same way the
// design does (fault ignored when undefined).
module tb_ttl_out_line;

`ifdef TTL_OUT_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  typedef struct packed {
    logic        clk_out;
    logic        busy;
    logic        done;
    logic [15:0] pcnt;
  } samp_t;

  logic clk_fpga = 1'b0;
  logic rst_n    = 1'b0;

  ttl_out_line_if #(.LEN_W(16)) bus ();

  ttl_out_line dut (
    .clk_fpga (clk_fpga),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_fpga = ~clk_fpga;

  samp_t       exp_q[$];
  samp_t       obs_q[$];
  logic [15:0] model_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic samp_t mk(input logic c, input logic b, input logic d, input logic [15:0] p);
    samp_t s;
    s.clk_out = c;
    s.busy    = b;
    s.done    = d;
    s.pcnt    = p;
    return s;
  endfunction

  // Expected samples from the first cycle after start up to and including
  // the done cycle. stop_at is the burst-relative cycle carrying stop.
  task automatic model_burst(input int len, input logic [1:0] f, input int stop_at);
    logic [1:0]  fe;
    int          hh;
    int          ll;
    int          k;
    logic [15:0] pc;
    bit          fin;
    fe  = FEN ? f : 2'b00;
    hh  = (fe == 2'b01) ? 20 : 50;
    ll  = (fe == 2'b10) ? 20 : 50;
    k   = 0;
    pc  = 16'd0;
    fin = 1'b0;
    while (!fin) begin
      if (fe == 2'b11) begin
        repeat (200) begin k++; exp_q.push_back(mk(1'b0, 1'b1, 1'b0, pc)); end
      end
      repeat (hh) begin k++; exp_q.push_back(mk(1'b1, 1'b1, 1'b0, pc)); end
      repeat (ll) begin k++; exp_q.push_back(mk(1'b0, 1'b1, 1'b0, pc)); end
      pc = pc + 16'd1;
      if ((stop_at > 0 && stop_at < k) || (len != 0 && pc == len[15:0])) begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, pc));
        fin = 1'b1;
      end
    end
    model_pc = pc;
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, model_pc));
  endtask

  // Entered #1 after a rising edge; leaves #1 after the start edge.
  task automatic kick(input logic [15:0] len, input logic [1:0] f);
    bus.start     = 1'b1;
    bus.burst_len = len;
    bus.fault     = f;
    @(posedge clk_fpga);
    #1;
    bus.start = 1'b0;
  endtask

  // Drives n cycles (optional stop / extra start pulse) and records outputs.
  task automatic run(input int n, input int stop_at, input int start_at, input logic [15:0] start_len);
    for (int k = 1; k <= n; k++) begin
      bus.stop = (k == stop_at);
      if (k == start_at) begin
        bus.start     = 1'b1;
        bus.burst_len = start_len;
      end
      @(negedge clk_fpga);
      obs_q.push_back(mk(bus.clk_out, bus.busy, bus.done, bus.period_cnt));
      @(posedge clk_fpga);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.burst_len = 16'd0; bus.fault = 2'b00;
    rst_n = 1'b0;
    #23;
    n_cmp++; if (bus.clk_out !== 1'b0) begin n_err++; $display("FAIL reset clk_out got %b exp 0", bus.clk_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done got %b exp 0", bus.done); end
    n_cmp++; if (bus.period_cnt !== 16'd0) begin n_err++; $display("FAIL reset period_cnt got %0d exp 0", bus.period_cnt); end
    @(negedge clk_fpga);
    rst_n = 1'b1;
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic test_normal_burst();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(3, 2'b00, 0); model_idle(3);
    kick(16'd3, 2'b00);
    run(exp_q.size(), 0, 0, 16'd0);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL normal_burst cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  task automatic test_short_high();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(2, 2'b01, 0); model_idle(2);
    kick(16'd2, 2'b01);
    run(exp_q.size(), 0, 0, 16'd0);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL short_high cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  task automatic test_short_low();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(2, 2'b10, 0); model_idle(2);
    kick(16'd2, 2'b10);
    run(exp_q.size(), 0, 0, 16'd0);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL short_low cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  task automatic test_stall();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(2, 2'b11, 0); model_idle(2);
    kick(16'd2, 2'b11);
    run(exp_q.size(), 0, 0, 16'd0);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  task automatic test_stop_mid_burst();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(0, 2'b00, 130); model_idle(3);
    kick(16'd0, 2'b00);
    run(exp_q.size(), 130, 0, 16'd0);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stop_mid_burst cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  // A second start (new length, different fault) mid-burst must be ignored.
  task automatic test_start_while_busy();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(2, 2'b00, 0); model_idle(2);
    kick(16'd2, 2'b00);
    bus.fault = 2'b11;
    run(exp_q.size(), 0, 60, 16'd5);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL start_while_busy cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  // Start presented in the done cycle launches the next burst right away.
  task automatic test_back_to_back();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(1, 2'b00, 0);
    model_burst(2, 2'b00, 0);
    model_idle(2);
    kick(16'd1, 2'b00);
    run(exp_q.size(), 0, 101, 16'd2);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  // Reset lands while the line is high in the second period (period_cnt = 1).
  task automatic test_reset_mid_burst();
    samp_t e, o;
    int    idx;
    exp_q.delete(); obs_q.delete();
    model_burst(3, 2'b00, 0);
    while (exp_q.size() > 124) void'(exp_q.pop_back());
    kick(16'd3, 2'b00);
    run(124, 0, 0, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.clk_out !== 1'b0) begin n_err++; $display("FAIL reset_mid clk_out got %b exp 0", bus.clk_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_mid busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.period_cnt !== 16'd0) begin n_err++; $display("FAIL reset_mid period_cnt got %0d exp 0", bus.period_cnt); end
    repeat (3) @(posedge clk_fpga);
    @(negedge clk_fpga);
    rst_n = 1'b1;
    @(posedge clk_fpga);
    #1;
    model_burst(1, 2'b00, 0); model_idle(2);
    kick(16'd1, 2'b00);
    run(exp_q.size() - obs_q.size(), 0, 0, 16'd0);
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid_burst sample %0d got clk=%b busy=%b done=%b cnt=%0d exp clk=%b busy=%b done=%b cnt=%0d",
                 idx, o.clk_out, o.busy, o.done, o.pcnt, e.clk_out, e.busy, e.done, e.pcnt);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_normal_burst();
    test_short_high();
    test_short_low();
    test_stall();
    test_stop_mid_burst();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
